// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: carries decoded control, operands, immediate and
// register specifiers from ID into EX, with stall (hold) and flush (bubble).
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              RegDst_in,
    input  logic [1:0]        ALU_Op_in,
    input  logic              ALU_Src_in,
    input  logic [DATA_W-1:0] Read_Data_1_in,
    input  logic [DATA_W-1:0] Read_Data_2_in,
    input  logic [DATA_W-1:0] sign_extend_in,
    input  logic [REG_W-1:0]  IF_ID_Rs_in,
    input  logic [REG_W-1:0]  IF_ID_Rt_in,
    input  logic [REG_W-1:0]  ID_Rd_in,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic              MemRead_out,
    output logic              MemWrite_out,
    output logic              RegDst_out,
    output logic [1:0]        ALU_Op_out,
    output logic              ALU_Src_out,
    output logic [DATA_W-1:0] Read_Data_1_out,
    output logic [DATA_W-1:0] Read_Data_2_out,
    output logic [DATA_W-1:0] sign_extend_out,
    output logic [REG_W-1:0]  ID_EX_Rs_Forward_out,
    output logic [REG_W-1:0]  ID_EX_Rt_Forward_out,
    output logic [REG_W-1:0]  ID_EX_Rs_MUX_out,
    output logic [REG_W-1:0]  ID_EX_Rt_MUX_out
);

    // Control bundle; zeroing it as a whole forms the bubble (NOP).
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_t;

    ctrl_t             ctrl_d,  ctrl_q;
    ctrl_t             ctrl_in;
    logic [DATA_W-1:0] rd1_d,   rd1_q;
    logic [DATA_W-1:0] rd2_d,   rd2_q;
    logic [DATA_W-1:0] imm_d,   imm_q;
    logic [REG_W-1:0]  rs_d,    rs_q;
    logic [REG_W-1:0]  rt_d,    rt_q;
    logic [REG_W-1:0]  rd_d,    rd_q;

    // Gather the individual control inputs into the bundle.
    always_comb begin
        ctrl_in            = '0;
        ctrl_in.reg_write  = RegWrite_in;
        ctrl_in.mem_to_reg = MemtoReg_in;
        ctrl_in.mem_read   = MemRead_in;
        ctrl_in.mem_write  = MemWrite_in;
        ctrl_in.reg_dst    = RegDst_in;
        ctrl_in.alu_op     = ALU_Op_in;
        ctrl_in.alu_src    = ALU_Src_in;
    end

    // Next state: flush loads a bubble (and beats stall), stall holds, else capture.
    always_comb begin
        ctrl_d = ctrl_q;
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        imm_d  = imm_q;
        rs_d   = rs_q;
        rt_d   = rt_q;
        rd_d   = rd_q;
        if (flush || !stall) begin
            ctrl_d = flush ? ctrl_t'('0) : ctrl_in;
            rd1_d  = Read_Data_1_in;
            rd2_d  = Read_Data_2_in;
            imm_d  = sign_extend_in;
            rs_d   = IF_ID_Rs_in;
            rt_d   = IF_ID_Rt_in;
            rd_d   = ID_Rd_in;
        end
    end

    // Pipeline state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            rd_q   <= rd_d;
        end
    end

    assign RegWrite_out         = ctrl_q.reg_write;
    assign MemtoReg_out         = ctrl_q.mem_to_reg;
    assign MemRead_out          = ctrl_q.mem_read;
    assign MemWrite_out         = ctrl_q.mem_write;
    assign RegDst_out           = ctrl_q.reg_dst;
    assign ALU_Op_out           = ctrl_q.alu_op;
    assign ALU_Src_out          = ctrl_q.alu_src;
    assign Read_Data_1_out      = rd1_q;
    assign Read_Data_2_out      = rd2_q;
    assign sign_extend_out      = imm_q;
    // Rt feeds both the forwarding unit and RegDst mux input 0; Rd feeds mux input 1.
    assign ID_EX_Rs_Forward_out = rs_q;
    assign ID_EX_Rt_Forward_out = rt_q;
    assign ID_EX_Rs_MUX_out     = rt_q;
    assign ID_EX_Rt_MUX_out     = rd_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed cases plus random traffic
// compared against a behavioural model of the stage register.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALU_Src_in;
    logic [1:0]  ALU_Op_in;
    logic [31:0] Read_Data_1_in, Read_Data_2_in, sign_extend_in;
    logic [4:0]  IF_ID_Rs_in, IF_ID_Rt_in, ID_Rd_in;
    logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, RegDst_out, ALU_Src_out;
    logic [1:0]  ALU_Op_out;
    logic [31:0] Read_Data_1_out, Read_Data_2_out, sign_extend_out;
    logic [4:0]  ID_EX_Rs_Forward_out, ID_EX_Rt_Forward_out, ID_EX_Rs_MUX_out, ID_EX_Rt_MUX_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model of what EX should see: control word {RW,MtoR,MR,MW,RD,OP[1:0],SRC}
    // plus the operand/specifier fields as named by the stage outputs.
    logic [7:0]  m_ctrl;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs_fwd, m_rt_fwd, m_rs_mux, m_rt_mux;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .RegDst_in(RegDst_in), .ALU_Op_in(ALU_Op_in),
        .ALU_Src_in(ALU_Src_in), .Read_Data_1_in(Read_Data_1_in),
        .Read_Data_2_in(Read_Data_2_in), .sign_extend_in(sign_extend_in),
        .IF_ID_Rs_in(IF_ID_Rs_in), .IF_ID_Rt_in(IF_ID_Rt_in), .ID_Rd_in(ID_Rd_in),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .RegDst_out(RegDst_out), .ALU_Op_out(ALU_Op_out),
        .ALU_Src_out(ALU_Src_out), .Read_Data_1_out(Read_Data_1_out),
        .Read_Data_2_out(Read_Data_2_out), .sign_extend_out(sign_extend_out),
        .ID_EX_Rs_Forward_out(ID_EX_Rs_Forward_out), .ID_EX_Rt_Forward_out(ID_EX_Rt_Forward_out),
        .ID_EX_Rs_MUX_out(ID_EX_Rs_MUX_out), .ID_EX_Rt_MUX_out(ID_EX_Rt_MUX_out)
    );

    // Single comparison point: counts every check and reports a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model.
    task automatic chk_all(input string tag);
        logic [7:0] ctrl_got;
        ctrl_got = {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
                    RegDst_out, ALU_Op_out, ALU_Src_out};
        chk({tag, ".ctrl"},   32'(ctrl_got),             32'(m_ctrl));
        chk({tag, ".rd1"},    Read_Data_1_out,           m_rd1);
        chk({tag, ".rd2"},    Read_Data_2_out,           m_rd2);
        chk({tag, ".imm"},    sign_extend_out,           m_imm);
        chk({tag, ".rs_fwd"}, 32'(ID_EX_Rs_Forward_out), 32'(m_rs_fwd));
        chk({tag, ".rt_fwd"}, 32'(ID_EX_Rt_Forward_out), 32'(m_rt_fwd));
        chk({tag, ".rs_mux"}, 32'(ID_EX_Rs_MUX_out),     32'(m_rs_mux));
        chk({tag, ".rt_mux"}, 32'(ID_EX_Rt_MUX_out),     32'(m_rt_mux));
    endtask

    task automatic model_clear();
        m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs_fwd = '0; m_rt_fwd = '0; m_rs_mux = '0; m_rt_mux = '0;
    endtask

    // What one clock edge does to the stage, from the current inputs.
    task automatic model_edge();
        if (!rst_n) begin
            model_clear();
        end else if (flush || !stall) begin
            m_ctrl   = flush ? 8'h00 : {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
                                        RegDst_in, ALU_Op_in, ALU_Src_in};
            m_rd1    = Read_Data_1_in;
            m_rd2    = Read_Data_2_in;
            m_imm    = sign_extend_in;
            m_rs_fwd = IF_ID_Rs_in;
            m_rt_fwd = IF_ID_Rt_in;
            m_rs_mux = IF_ID_Rt_in;
            m_rt_mux = ID_Rd_in;
        end
    endtask

    // Advance one rising edge, update the model, settle away from the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_ctrl(input logic [7:0] c);
        {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
         RegDst_in, ALU_Op_in, ALU_Src_in} = c;
    endtask

    task automatic randomize_inputs();
        set_ctrl(8'($urandom));
        Read_Data_1_in = $urandom;
        Read_Data_2_in = $urandom;
        sign_extend_in = $urandom;
        IF_ID_Rs_in    = 5'($urandom);
        IF_ID_Rt_in    = 5'($urandom);
        ID_Rd_in       = 5'($urandom);
    endtask

    initial begin
        // Reset with nonzero inputs: outputs clear before any clock edge.
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_ctrl(8'hFF);
        Read_Data_1_in = 32'h1111_1111; Read_Data_2_in = 32'h2222_2222;
        sign_extend_in = 32'h3333_3333;
        IF_ID_Rs_in = 5'd7; IF_ID_Rt_in = 5'd8; ID_Rd_in = 5'd9;
        model_clear();
        #3;
        chk_all("reset");
        tick();
        chk_all("reset_held");
        #2 rst_n = 1'b1;

        // Pass-through example; unchanged before the edge, captured after it.
        set_ctrl(8'b0000_0100);
        Read_Data_1_in = 32'hA; IF_ID_Rs_in = 5'd3; IF_ID_Rt_in = 5'd4; ID_Rd_in = 5'd5;
        #1;
        chk_all("pass_pre");
        tick();
        chk("pass.rd1", Read_Data_1_out, 32'hA);
        chk("pass.op", 32'(ALU_Op_out), 32'h2);
        chk("pass.rs_fwd", 32'(ID_EX_Rs_Forward_out), 32'd3);
        chk("pass.rt_fwd", 32'(ID_EX_Rt_Forward_out), 32'd4);
        chk("pass.rs_mux", 32'(ID_EX_Rs_MUX_out), 32'd4);
        chk("pass.rt_mux", 32'(ID_EX_Rt_MUX_out), 32'd5);
        chk_all("pass");

        // Stall holds for three edges, then releases.
        Read_Data_1_in = 32'h1234;
        tick();
        chk("stall_load.rd1", Read_Data_1_out, 32'h1234);
        stall = 1'b1; Read_Data_1_in = 32'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold.rd1", Read_Data_1_out, 32'h1234);
        end
        stall = 1'b0;
        tick();
        chk("stall_release.rd1", Read_Data_1_out, 32'hFFFF);
        chk_all("stall_release");

        // Flush: control zeroed, data loads; flush beats stall.
        set_ctrl(8'hFF);
        tick();
        chk("preflush.ctrl", 32'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
                                  RegDst_out, ALU_Op_out, ALU_Src_out}), 32'hFF);
        flush = 1'b1; sign_extend_in = 32'hDEAD_BEEF;
        tick();
        chk("flush.ctrl", 32'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
                               RegDst_out, ALU_Op_out, ALU_Src_out}), 32'h0);
        chk("flush.imm", sign_extend_out, 32'hDEAD_BEEF);
        flush = 1'b0;
        tick();
        stall = 1'b1; flush = 1'b1; sign_extend_in = 32'hCAFE_F00D;
        tick();
        chk("flush_stall.ctrl", 32'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
                                     RegDst_out, ALU_Op_out, ALU_Src_out}), 32'h0);
        chk("flush_stall.imm", sign_extend_out, 32'hCAFE_F00D);
        chk_all("flush_stall");
        stall = 1'b0; flush = 1'b0;

        // Async reset between edges, even while stalled.
        randomize_inputs();
        tick();
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk_all("async_rst");
        #1 rst_n = 1'b1; stall = 1'b0;
        randomize_inputs();
        tick();
        chk_all("after_rst");

        // Random traffic with occasional stall/flush and rare reset pulses.
        for (int i = 0; i < 1000; i++) begin
            randomize_inputs();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1;
                model_clear();
                chk_all("rnd_rst");
                rst_n = 1'b1;
            end
            tick();
            chk_all("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
